// File: rtl/conv_sched.sv
// conv_sched: 5x5 convolution scheduler and MAC datapath for one channel.
// Walks the output grid, reads five kernel rows per pixel, streams results.
module conv_sched #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10,
    parameter int FRAC   = 7,
    parameter int RELU   = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [224:0]      weight,
    input  logic [8:0]        bias,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [44:0]       rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        out_data,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y
);

    localparam int OUT_W = IMG_W - 4;
    localparam int OUT_H = IMG_H - 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_ky;
    logic [2:0]          r_ky_d;
    logic                r_rd_en;
    logic                r_rd_en_d;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_base;
    logic [7:0]          r_ox;
    logic [7:0]          r_oy;
    logic signed [23:0]  r_acc;
    logic [224:0]        r_weight;
    logic signed [8:0]   r_bias;
    logic                r_busy;
    logic                r_done;
    logic                r_out_valid;
    logic [8:0]          r_out_data;
    logic [7:0]          r_out_x;
    logic [7:0]          r_out_y;

    logic [44:0]         w_row;
    logic signed [8:0]   w_pix [5];
    logic signed [8:0]   w_wgt [5];
    logic signed [17:0]  w_prod [5];
    logic signed [23:0]  w_dot;
    logic signed [23:0]  w_acc_next;
    logic signed [31:0]  w_biased;
    logic signed [31:0]  w_res;
    logic [8:0]          w_sat;
    logic                w_last_x;
    logic                w_last_y;
    logic [ADDR_W-1:0]   w_next_base;

    // Kernel row matching the data returned this cycle
    always_comb begin
        case (r_ky_d)
            3'd0:    w_row = r_weight[224 -: 45];
            3'd1:    w_row = r_weight[179 -: 45];
            3'd2:    w_row = r_weight[134 -: 45];
            3'd3:    w_row = r_weight[89 -: 45];
            3'd4:    w_row = r_weight[44 -: 45];
            default: w_row = '0;
        endcase
    end

    for (genvar c = 0; c < 5; c++) begin : g_lane
        assign w_pix[c]  = rd_data[44-9*c -: 9];
        assign w_wgt[c]  = w_row[44-9*c -: 9];
        assign w_prod[c] = 18'(w_pix[c]) * 18'(w_wgt[c]);
    end

    always_comb begin
        w_dot = '0;
        for (int c = 0; c < 5; c++) begin
            w_dot = w_dot + 24'(w_prod[c]);
        end
    end

    assign w_acc_next = r_acc + w_dot;
    assign w_biased   = 32'(w_acc_next) + (32'(r_bias) <<< FRAC);
    assign w_res      = w_biased >>> FRAC;

    always_comb begin
        w_sat = w_res[8:0];
        if (RELU != 0) begin
            if (w_res < 0) begin
                w_sat = 9'd0;
            end else if (w_res > 255) begin
                w_sat = 9'd255;
            end
        end else begin
            if (w_res < -256) begin
                w_sat = 9'h100;
            end else if (w_res > 255) begin
                w_sat = 9'h0ff;
            end
        end
    end

    assign w_last_x = (r_ox == 8'(OUT_W - 1));
    assign w_last_y = (r_oy == 8'(OUT_H - 1));

    // Row wrap skips the four columns the kernel cannot start in
    assign w_next_base = w_last_x ? r_base + ADDR_W'(5)
                                  : r_base + ADDR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_ky        <= '0;
            r_ky_d      <= '0;
            r_rd_en     <= 1'b0;
            r_rd_en_d   <= 1'b0;
            r_rd_addr   <= '0;
            r_base      <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_acc       <= '0;
            r_weight    <= '0;
            r_bias      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            r_rd_en_d <= r_rd_en;
            r_ky_d    <= r_ky;
            r_done    <= 1'b0;
            if (r_rd_en_d) begin
                r_acc <= w_acc_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_weight  <= weight;
                        r_bias    <= bias;
                        r_busy    <= 1'b1;
                        r_ox      <= '0;
                        r_oy      <= '0;
                        r_base    <= '0;
                        r_rd_addr <= '0;
                        r_ky      <= '0;
                        r_rd_en   <= 1'b1;
                        r_acc     <= '0;
                        r_state   <= S_ROW;
                    end
                end
                S_ROW: begin
                    if (r_ky == 3'd4) begin
                        r_rd_en <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_ky      <= r_ky + 3'd1;
                        r_rd_addr <= r_rd_addr + ADDR_W'(IMG_W);
                    end
                end
                S_DRAIN: begin
                    r_out_data  <= w_sat;
                    r_out_x     <= r_ox;
                    r_out_y     <= r_oy;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_x && w_last_y) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_ky      <= '0;
                            r_rd_en   <= 1'b1;
                            r_acc     <= '0;
                            r_base    <= w_next_base;
                            r_rd_addr <= w_next_base;
                            r_state   <= S_ROW;
                            if (w_last_x) begin
                                r_ox <= '0;
                                r_oy <= r_oy + 8'd1;
                            end else begin
                                r_ox <= r_ox + 8'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: scoreboard bench for conv_sched (RELU=1 28x28 and RELU=0 8x8).
// Expected outputs are queued at frame start and popped by output monitors.
module tb_conv_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn, start, start1, out_ready, ready1;
    logic [224:0] weight;
    logic [8:0]   bias;

    logic         busy, done, rd_en, out_valid;
    logic [9:0]   rd_addr;
    logic [44:0]  rd_data = '0;
    logic [8:0]   out_data;
    logic [7:0]   out_x, out_y;

    logic         busy1, done1, rd_en1, out_valid1;
    logic [5:0]   rd_addr1;
    logic [44:0]  rd_data1 = '0;
    logic [8:0]   out_data1;
    logic [7:0]   out_x1, out_y1;

    conv_sched u_dut (
        .clk(clk), .rstn(rstn), .start(start), .weight(weight), .bias(bias),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y)
    );

    conv_sched #(.IMG_W(8), .IMG_H(8), .ADDR_W(6), .FRAC(7), .RELU(0)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .weight(weight), .bias(bias),
        .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(ready1),
        .out_data(out_data1), .out_x(out_x1), .out_y(out_y1)
    );

    typedef struct {
        int x;
        int y;
        int d;
    } exp_t;

    int   n_tests = 0;
    int   n_fail = 0;
    int   pix0 [784];
    int   pix1 [64];
    int   wk [25];
    int   bias_i = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e0, e1;
    int   addr_log [$];
    int   log_en = 0;
    int   cyc = 0;
    int   last_hs = 0;
    int   hs0 = 0;
    int   hs1 = 0;
    int   done0_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [44:0] pack(input bit which, input int a);
        logic [44:0] v;
        v = '0;
        for (int c = 0; c < 5; c++) begin
            if (which) begin
                if (a + c < 64) v[44-9*c -: 9] = 9'(pix1[a+c]);
            end else begin
                if (a + c < 784) v[44-9*c -: 9] = 9'(pix0[a+c]);
            end
        end
        return v;
    endfunction

    // Window RAM models: one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= pack(1'b0, int'(rd_addr));
        if (rd_en1) rd_data1 <= pack(1'b1, int'(rd_addr1));
    end

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            hs0++;
            last_hs = cyc;
            n_tests++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL out0_extra: got (%0d,%0d)=%0d expected none",
                         out_x, out_y, out_data);
            end else begin
                e0 = q0.pop_front();
                if (out_data !== 9'(e0.d) || out_x !== 8'(e0.x) ||
                    out_y !== 8'(e0.y)) begin
                    n_fail++;
                    $display("FAIL out0: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                             out_x, out_y, out_data, e0.x, e0.y, e0.d);
                end
            end
        end
        if (rstn && done) begin
            done0_cnt++;
            chk("done_after_hs", cyc - last_hs, 1);
            chk("busy_at_done", int'(busy), 0);
        end
        if (rstn && rd_en && log_en != 0) addr_log.push_back(int'(rd_addr));
    end

    always @(negedge clk) begin
        if (rstn && out_valid1 && ready1) begin
            hs1++;
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL out1_extra: got (%0d,%0d)=%0d expected none",
                         out_x1, out_y1, $signed(out_data1));
            end else begin
                e1 = q1.pop_front();
                if (out_data1 !== 9'(e1.d) || out_x1 !== 8'(e1.x) ||
                    out_y1 !== 8'(e1.y)) begin
                    n_fail++;
                    $display("FAIL out1: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                             out_x1, out_y1, $signed(out_data1), e1.x, e1.y, e1.d);
                end
            end
        end
    end

    function automatic int golden(input bit which, input int ox, input int oy);
        int acc, r, w, p;
        acc = 0;
        w = which ? 8 : 28;
        for (int ky = 0; ky < 5; ky++) begin
            for (int c = 0; c < 5; c++) begin
                p = which ? pix1[(oy+ky)*w+ox+c] : pix0[(oy+ky)*w+ox+c];
                acc += p * wk[ky*5+c];
            end
        end
        r = (acc + bias_i * 128) >>> 7;
        if (!which) begin
            if (r < 0) r = 0;
            if (r > 255) r = 255;
        end else begin
            if (r < -256) r = -256;
            if (r > 255) r = 255;
        end
        return r;
    endfunction

    task automatic apply_w();
        for (int k = 0; k < 25; k++) weight[224-9*k -: 9] = 9'(wk[k]);
        bias = 9'(bias_i);
    endtask

    task automatic set_w(input int v);
        for (int k = 0; k < 25; k++) wk[k] = v;
        apply_w();
    endtask

    task automatic ramp_w(input int seed);
        for (int k = 0; k < 25; k++) wk[k] = ((k * 13 + seed) % 31) - 15;
        apply_w();
    endtask

    task automatic fill(input int v);
        foreach (pix0[i]) pix0[i] = v;
        foreach (pix1[i]) pix1[i] = v;
    endtask

    task automatic ramp_pix(input int seed);
        foreach (pix0[i]) pix0[i] = ((i * 37 + seed) % 201) - 100;
        foreach (pix1[i]) pix1[i] = ((i * 53 + seed) % 241) - 120;
    endtask

    task automatic push(input bit which, input bit model, input int val);
        int ow;
        ow = which ? 4 : 24;
        for (int oy = 0; oy < ow; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                if (which) q1.push_back('{ox, oy, model ? golden(1'b1, ox, oy) : val});
                else       q0.push_back('{ox, oy, model ? golden(1'b0, ox, oy) : val});
            end
        end
    endtask

    task automatic start0();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done0(input string name);
        int n;
        n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, int'(done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run0(input string name);
        hs0 = 0;
        done0_cnt = 0;
        start0();
        wait_done0(name);
        chk({name, "_outputs"}, hs0, 576);
        chk({name, "_done_count"}, done0_cnt, 1);
        chk({name, "_queue_left"}, q0.size(), 0);
    endtask

    task automatic run1(input string name);
        int n;
        hs1 = 0;
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        while (!done1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, int'(done1), 1);
        repeat (3) @(negedge clk);
        chk({name, "_outputs"}, hs1, 16);
        chk({name, "_queue_left"}, q1.size(), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_rd_en"}, int'(rd_en), 0);
        chk({name, "_rd_addr"}, int'(rd_addr), 0);
        chk({name, "_out_valid"}, int'(out_valid), 0);
        chk({name, "_out_data"}, int'(out_data), 0);
        chk({name, "_out_x"}, int'(out_x), 0);
        chk({name, "_out_y"}, int'(out_y), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, bad;
        logic [5:0] pat;
        logic [8:0] hd;
        logic [7:0] hx, hy;

        rstn = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        out_ready = 1'b1;
        ready1 = 1'b1;
        weight = '0;
        bias = '0;
        fill(0);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Uniform frame with latency and address-sequence checks
        fill(16);
        bias_i = 0;
        set_w(8);
        push(1'b0, 1'b0, 25);
        hs0 = 0;
        done0_cnt = 0;
        addr_log.delete();
        log_en = 1;
        chk("busy_idle", int'(busy), 0);
        start0();
        n = 0;
        pat = '0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_rise", int'(busy), 1);
            if (n <= 6) pat = {pat[4:0], rd_en};
        end
        chk("first_valid_latency", n, 7);
        chk("rd_en_pattern", int'(pat), 'b111110);
        wait_done0("uniform");
        log_en = 0;
        chk("uniform_outputs", hs0, 576);
        chk("uniform_done_count", done0_cnt, 1);
        chk("uniform_queue_left", q0.size(), 0);
        chk("busy_after_done", int'(busy), 0);
        chk("addr_count", addr_log.size(), 2880);
        if (addr_log.size() == 2880) begin
            for (int k = 0; k < 5; k++) begin
                chk("addr_px00", addr_log[k], 28 * k);
                chk("addr_px10", addr_log[5+k], 1 + 28 * k);
                chk("addr_px2323", addr_log[2875+k], 667 + 28 * k);
            end
        end

        fill(127);
        set_w(127);
        push(1'b0, 1'b0, 255);
        run0("sat_pos");

        set_w(-128);
        push(1'b0, 1'b0, 0);
        run0("sat_neg_relu");

        fill(0);
        bias_i = 5;
        set_w(8);
        push(1'b0, 1'b0, 5);
        run0("bias_pos");

        bias_i = -5;
        apply_w();
        push(1'b0, 1'b0, 0);
        run0("bias_neg_relu");

        // Signed-saturation instance
        fill(127);
        bias_i = 0;
        set_w(-128);
        push(1'b1, 1'b0, -256);
        run1("sat_neg_signed");

        fill(0);
        bias_i = -5;
        set_w(8);
        push(1'b1, 1'b0, -5);
        run1("bias_neg_signed");

        ramp_pix(7);
        bias_i = 3;
        ramp_w(4);
        push(1'b1, 1'b1, 0);
        run1("ramp_signed");

        // Backpressure at (3,0), then start pulses mid-frame with new weights
        push(1'b0, 1'b1, 0);
        hs0 = 0;
        done0_cnt = 0;
        start0();
        n = 0;
        while (!(rd_en && rd_addr == 10'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_px30", int'(rd_en && rd_addr == 10'd3), 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        hd = out_data;
        hx = out_x;
        hy = out_y;
        chk("bp_x", int'(hx), 3);
        chk("bp_y", int'(hy), 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || rd_en !== 1'b0 || out_data !== hd ||
                out_x !== hx || out_y !== hy) bad++;
        end
        chk("bp_frozen_cycles", bad, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (40) @(posedge clk);
        weight = '1;
        bias = 9'd100;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1 start = ~start;
        end
        start = 1'b0;
        wait_done0("bp_midstart");
        chk("bp_midstart_outputs", hs0, 576);
        chk("bp_midstart_done_count", done0_cnt, 1);
        chk("bp_midstart_queue_left", q0.size(), 0);

        // Asynchronous reset mid-frame, then a clean re-run
        ramp_pix(19);
        bias_i = -2;
        ramp_w(11);
        push(1'b0, 1'b1, 0);
        done0_cnt = 0;
        start0();
        n = 0;
        while (!(out_valid && out_x == 8'd5 && out_y == 8'd2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_px52", int'(out_valid && out_x == 8'd5 && out_y == 8'd2), 1);
        #2 rstn = 1'b0;
        #1 chk_zero("midreset");
        q0.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("midreset_no_done", done0_cnt, 0);
        push(1'b0, 1'b1, 0);
        run0("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
# conv_sched

Frame-level scheduler and datapath for one 5x5 convolution channel of the CNN accelerator. On `start`, it walks every valid output position of an `IMG_W` x `IMG_H` feature map and, for each position, issues five kernel-row reads to the window RAM. It runs five 9x9 signed multiply lanes per cycle, accumulates the 25 products, adds the bias, rescales and applies ReLU/saturation. Results stream out over a valid/ready handshake to the pooling stage.

## Interface
- `IMG_W`, 28, input map width (pixels)
- `IMG_H`, 28, input map height
- `ADDR_W`, 10, window-RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- `FRAC`, 7, fixed-point fraction bits; arithmetic right shift applied to the sum
- `RELU`, 1, 1 = clamp negatives to 0; 0 = signed saturation
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `start`  in  1  frame start pulse; honoured only in IDLE
- `weight`  in  225  5x5 signed 9-bit kernel; row ky at [224-45*ky -: 45], column c at bit offset 44-9c within the row
- `bias`  in  9  signed bias
- `busy`  out  1  high from the cycle after an accepted start until done
- `done`  out  1  one-cycle pulse after the last output handshake
- `rd_en`  out  1  window-RAM read strobe
- `rd_addr`  out  ADDR_W  = (oy+ky)*IMG_W + ox
- `rd_data`  in  45  pixels x..x+4 of row y, returned one cycle after rd_en; pixel c at [44-9c -: 9]
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts
- `out_data`  out  9  result (unsigned 0..255 if RELU=1, else signed)
- `out_x`, `out_y`  out  8 each  output coordinate of out_data

## Operation
- Output grid: OUT_W = IMG_W-4, OUT_H = IMG_H-4, raster order (ox fastest).
- `weight` and `bias` are latched into internal registers on an accepted start. They are ignored for the rest of the frame.
- States and transitions:
  - IDLE -> ROW on start.
  - ROW: rd_en=1 for ky=0..4 over 5 consecutive cycles, then -> DRAIN.
  - DRAIN: one cycle; last row data is accumulated. -> OUT.
  - OUT: out_valid=1. On out_ready: -> ROW for the next pixel, or -> DONE after the last pixel.
  - DONE: done=1 for one cycle, then -> IDLE.
- MAC: each cycle that the delayed rd_en is high, acc += sum over c of rd_data[c] * weight[ky_d][c], with ky_d the ky delayed one cycle. acc is cleared when ROW is entered at ky=0.
- Widths: product 18b signed, acc 24b signed (25 products need 23b).
- Result: r = (acc + (sext(bias) <<< FRAC)) >>> FRAC.
  - RELU=1: out = r<0 ? 0 : min(r,255).
  - RELU=0: out = clamp(r, -256, 255).
- out_data, out_x and out_y are registered on entry to OUT. They are held stable until the handshake.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_x=0, out_y=0; state IDLE; acc=0.
- start accepted at cycle T: rd_en is high in T+1..T+5, DRAIN is T+6, out_valid rises at T+7.
- Per-pixel minimum is 7 cycles (5 ROW + 1 DRAIN + 1 OUT). The next pixel's first rd_en is in the cycle after the out_valid&&out_ready cycle.
- Backpressure: while out_valid=1 and out_ready=0, there is no rd_en, all outputs are frozen, and coordinates do not advance.
- Handshake on the last pixel at cycle H: done=1 at H+1 and busy falls at H+1. A start is accepted again from H+2 (IDLE).
- start while busy or in DONE is ignored. A simultaneous start and out_ready in OUT has no effect on start.
- rstn low at any time returns the block to IDLE within the same cycle (asynchronous reset) and clears all outputs. The partial frame is discarded and no done is issued.
- Coordinate wrap: ox==OUT_W-1 goes to ox=0, oy+1. oy==OUT_H-1 with ox==OUT_W-1 is the last pixel.

## Test plan
- Uniform case (pixels 16, weights 8, bias 0, FRAC=7): each product 128, sum 3200, result 25 at all 576 outputs. done asserts once after output (23,23).
- Saturation:
  - pixels 127, weights 127: sum 403225>>7 = 3150, so out=255.
  - weights -128, RELU=1: out=0.
  - same with RELU=0: out=-256.
- Bias (pixels 0): bias 5 gives out=5; bias -5 gives 0 with RELU=1 and -5 with RELU=0.
- Address sequence:
  - pixel (0,0): rd_addr 0,28,56,84,112.
  - pixel (1,0): 1,29,57,85,113.
  - pixel (23,23): 667..779 in steps of 28.
  - first out_valid exactly 7 cycles after start.
- Backpressure: hold out_ready low for 10 cycles at pixel (3,0). out_valid stays high, out_data/x/y are stable and no rd_en is issued. Resumes cleanly with the correct value.
- Control:
  - start pulsed mid-frame is ignored (output count remains 576).
  - rstn asserted at pixel (5,2) clears all outputs immediately.
  - A new start then re-runs the frame from (0,0) and matches the golden model.
